cam_window_capture: RTL and testbench

- Parametrised successor to the fixed 256x256 camera-to-buffer writer.
- Assembles the camera byte stream into pixels and tracks the h/v position.
- Crops a runtime-positioned window with optional 1/2/4 decimation and drives the frame buffer write port.
- Adds frame-boundary freeze, single-shot snapshot and line-length error detection. Sits between the camera sync logic and the Buffer write port.

---
 rtl/cam_window_capture.sv | 216 +++++++++++++++++++++
 tb/tb_cam_window_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_window_capture.sv
// rtl/cam_window_capture.sv - camera byte stream to windowed, decimated frame buffer writer
module cam_window_capture #(
    parameter int DATA_W   = 8,
    parameter int PIX_W    = 16,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WIN_W    = 256,
    parameter int WIN_H    = 256,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              capture_en,
    input  logic              snap_req,
    input  logic [9:0]        win_x0,
    input  logic [9:0]        win_y0,
    input  logic [1:0]        decim,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic              frame_valid,
    output logic              line_err,
    output logic              busy
);

    localparam int BPP   = PIX_W / DATA_W;
    localparam int COL_W = $clog2(WIN_W);
    localparam int ROW_W = $clog2(WIN_H);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

    state_t              state_q, state_d;
    logic                shot_q, shot_d;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [10:0]         hcnt_q, hcnt_d;
    logic [10:0]         vcnt_q, vcnt_d;
    logic [9:0]          x0_q, x0_d;
    logic [9:0]          y0_q, y0_d;
    logic [1:0]          dec_q, dec_d;
    logic [ROW_W:0]      rows_q, rows_d;
    logic                row_wr_q, row_wr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]    wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_valid_q, frame_valid_d;
    logic                line_err_q, line_err_d;
    logic                busy_q, busy_d;

    logic                vs_fall, vs_rise, href_fall, pix_done, wr_hit;
    logic                hit_x, hit_y;
    logic [10:0]         x0_ext, y0_ext, span_x, span_y, dx, dy, dmask;
    logic [COL_W-1:0]    col_idx;
    logic [ROW_W-1:0]    row_idx;
    logic [PIX_W-1:0]    pix_data;

    // Pixel assembly, position tracking, window test and capture FSM next-state
    always_comb begin
        vs_fall   = vsync_q & ~cam_vsync;
        vs_rise   = ~vsync_q & cam_vsync;
        href_fall = href_q & ~cam_href;
        pix_done  = cam_href & ((BPP == 1) | phase_q);
        pix_data  = PIX_W'({hi_q, cam_data});

        vsync_d = cam_vsync;
        href_d  = cam_href;
        // Byte phase only advances for two-byte pixels and restarts with every line
        phase_d = cam_href ? ((BPP == 2) ? ~phase_q : 1'b0) : 1'b0;
        hi_d    = (cam_href && !phase_q) ? cam_data : hi_q;

        hcnt_d = hcnt_q;
        if (href_fall)     hcnt_d = 11'd0;
        else if (pix_done) hcnt_d = hcnt_q + 11'd1;

        vcnt_d = vcnt_q;
        if (cam_vsync)                        vcnt_d = 11'd0;
        else if (href_fall && hcnt_q != 11'd0) vcnt_d = vcnt_q + 11'd1;

        // 11-bit window bounds so x0 + WIN_W*step never wraps
        x0_ext  = {1'b0, x0_q};
        y0_ext  = {1'b0, y0_q};
        span_x  = x0_ext + (11'(WIN_W) << dec_q);
        span_y  = y0_ext + (11'(WIN_H) << dec_q);
        dx      = hcnt_q - x0_ext;
        dy      = vcnt_q - y0_ext;
        dmask   = (11'd1 << dec_q) - 11'd1;
        hit_x   = (hcnt_q >= x0_ext) && (hcnt_q < span_x) && ((dx & dmask) == 11'd0);
        hit_y   = (vcnt_q >= y0_ext) && (vcnt_q < span_y) && ((dy & dmask) == 11'd0)
                  && (vcnt_q < 11'(V_ACTIVE));
        col_idx = COL_W'(dx >> dec_q);
        row_idx = ROW_W'(dy >> dec_q);
        wr_hit  = (state_q == S_ACTIVE) && pix_done && hit_x && hit_y;

        wr_en_d   = wr_hit;
        wr_addr_d = wr_hit ? ADDR_W'({row_idx, col_idx}) : wr_addr_q;
        wr_data_d = wr_hit ? pix_data : wr_data_q;

        // Count distinct rows written this frame to judge completeness
        rows_d   = rows_q;
        row_wr_d = row_wr_q;
        if (wr_hit && !row_wr_q) rows_d = rows_q + 1'b1;
        if (href_fall)           row_wr_d = 1'b0;
        else if (wr_hit)         row_wr_d = 1'b1;

        state_d       = state_q;
        shot_d        = shot_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        dec_d         = dec_q;
        frame_done_d  = 1'b0;
        frame_valid_d = frame_valid_q;

        // A new error in the same cycle as err_clr keeps the flag set
        line_err_d = line_err_q & ~err_clr;
        if (state_q == S_ACTIVE && href_fall && (hcnt_q != 11'(H_ACTIVE) || phase_q))
            line_err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (capture_en || snap_req) begin
                    state_d = S_ARMED;
                    shot_d  = snap_req;
                end
            end
            S_ARMED: begin
                if (vs_fall) begin
                    state_d  = S_ACTIVE;
                    x0_d     = win_x0;
                    y0_d     = win_y0;
                    dec_d    = (decim == 2'd3) ? 2'd2 : decim;
                    rows_d   = '0;
                    row_wr_d = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    frame_done_d  = 1'b1;
                    frame_valid_d = (rows_d == (ROW_W+1)'(WIN_H));
                    if (capture_en && !shot_q) begin
                        state_d = S_ARMED;
                    end else begin
                        state_d = S_IDLE;
                        shot_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shot_q        <= 1'b0;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            dec_q         <= '0;
            rows_q        <= '0;
            row_wr_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            line_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shot_q        <= shot_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            dec_q         <= dec_d;
            rows_q        <= rows_d;
            row_wr_q      <= row_wr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            frame_valid_q <= frame_valid_d;
            line_err_q    <= line_err_d;
            busy_q        <= busy_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign line_err    = line_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cam_window_capture.sv
// tb/tb_cam_window_capture.sv - directed bench for cam_window_capture on a reduced 16x12 sensor, 8x8 window
module tb_cam_window_capture;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cam_vsync, cam_href;
    logic [7:0]    cam_data;
    logic          capture_en, snap_req, err_clr;
    logic [9:0]    win_x0, win_y0;
    logic [1:0]    decim;
    logic          wr_en, frame_done, frame_valid, line_err, busy;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int wcount, bad, fdcnt, first_cyc, mark_cyc, mark_x, mark_y, wc_at_rst;
    int ex_x0, ex_y0, ex_step;
    logic [15:0] mem [0:63];
    logic [4:0]  rst_snap;

    cam_window_capture #(
        .DATA_W(8), .PIX_W(16), .H_ACTIVE(H), .V_ACTIVE(V),
        .WIN_W(8), .WIN_H(8), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .capture_en(capture_en), .snap_req(snap_req),
        .win_x0(win_x0), .win_y0(win_y0), .decim(decim), .err_clr(err_clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .frame_valid(frame_valid), .line_err(line_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: stores writes and checks each pixel against its source position
    always @(negedge clk) begin
        logic [15:0] exp_pix;
        if (wr_en) begin
            if (wcount == 0) first_cyc = cyc;
            mem[wr_addr] = wr_data;
            exp_pix = {8'(ex_y0 + int'(wr_addr >> 3) * ex_step),
                       8'(ex_x0 + int'(wr_addr & 6'd7) * ex_step)};
            if (wr_data !== exp_pix) bad++;
            wcount++;
        end
        if (frame_done) fdcnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        wcount = 0; bad = 0; fdcnt = 0; first_cyc = -1; mark_cyc = -1;
    endtask

    task automatic set_win(input int x0, input int y0, input int d);
        win_x0 = 10'(x0); win_y0 = 10'(y0); decim = 2'(d);
        ex_x0 = x0; ex_y0 = y0; ex_step = (d == 0) ? 1 : (d == 1) ? 2 : 4;
        mark_x = x0; mark_y = y0;
    endtask

    task automatic send_frame(input int short_ln, input int odd_ln, input int drop_ln, input int rst_ln);
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (4) tick();
        for (int r = 0; r < V; r++) begin
            int ncols;
            if (r == drop_ln) capture_en = 1'b0;
            if (r == rst_ln) begin
                rst_n = 1'b0;
                #1;
                rst_snap  = {wr_en, frame_done, frame_valid, line_err, busy};
                wc_at_rst = wcount;
                tick();
                rst_n = 1'b1;
            end
            ncols = (r == short_ln) ? H - 1 : H;
            cam_href = 1'b1;
            for (int c = 0; c < ncols; c++) begin
                cam_data = r[7:0];
                tick();
                cam_data = c[7:0];
                if (r == mark_y && c == mark_x) mark_cyc = cyc;
                tick();
            end
            if (r == odd_ln) begin
                cam_data = 8'hAA;
                tick();
            end
            cam_href = 1'b0;
            repeat (4) tick();
        end
        cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
        capture_en = 1'b0; snap_req = 1'b0; err_clr = 1'b0;
        set_win(0, 0, 0);
        clear_mon();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_line_err", 32'(line_err), 0);
        chk("rst_busy", 32'(busy), 0);

        // Full window, no decimation
        capture_en = 1'b1;
        tick();
        chk("arm_busy", 32'(busy), 1);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("full_writes", 32'(wcount), 64);
        chk("full_bad", 32'(bad), 0);
        chk("full_done", 32'(fdcnt), 1);
        chk("full_valid", 32'(frame_valid), 1);
        chk("full_lerr", 32'(line_err), 0);
        chk("full_latency", 32'(first_cyc), 32'(mark_cyc + 1));
        chk("full_mem9", 32'(mem[9]), 32'h0101);
        chk("full_mem63", 32'(mem[63]), 32'h0707);
        chk("full_busy", 32'(busy), 1);

        // Offset window, every 2nd pixel: 6 cols x 5 rows fit in the sensor
        set_win(4, 2, 1);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("dec1_writes", 32'(wcount), 30);
        chk("dec1_bad", 32'(bad), 0);
        chk("dec1_valid", 32'(frame_valid), 0);
        chk("dec1_mem0", 32'(mem[0]), 32'h0204);
        chk("dec1_mem1", 32'(mem[1]), 32'h0206);
        chk("dec1_mem8", 32'(mem[8]), 32'h0404);
        chk("dec1_latency", 32'(first_cyc), 32'(mark_cyc + 1));

        // decim=3 behaves as every 4th pixel
        set_win(1, 0, 3);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("dec3_writes", 32'(wcount), 12);
        chk("dec3_bad", 32'(bad), 0);
        chk("dec3_mem1", 32'(mem[1]), 32'h0005);
        chk("dec3_mem8", 32'(mem[8]), 32'h0401);

        // capture_en dropped mid-frame: frame completes, next one is not captured
        set_win(0, 0, 0);
        clear_mon();
        send_frame(-1, -1, 5, -1);
        chk("drop_writes", 32'(wcount), 64);
        chk("drop_valid", 32'(frame_valid), 1);
        chk("drop_busy", 32'(busy), 0);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("drop_next_writes", 32'(wcount), 0);
        chk("drop_next_done", 32'(fdcnt), 0);

        // Single-shot snapshot over three frames
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("snap_busy", 32'(busy), 1);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("snap_writes1", 32'(wcount), 64);
        chk("snap_done1", 32'(fdcnt), 1);
        chk("snap_busy_after", 32'(busy), 0);
        send_frame(-1, -1, -1, -1);
        send_frame(-1, -1, -1, -1);
        chk("snap_writes3", 32'(wcount), 64);
        chk("snap_done3", 32'(fdcnt), 1);

        // Line length and byte phase errors, sticky until err_clr
        capture_en = 1'b1;
        tick();
        clear_mon();
        send_frame(3, -1, -1, -1);
        chk("short_lerr", 32'(line_err), 1);
        chk("short_writes", 32'(wcount), 64);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr1_lerr", 32'(line_err), 0);
        send_frame(-1, 7, -1, -1);
        chk("odd_lerr", 32'(line_err), 1);
        send_frame(-1, -1, -1, -1);
        chk("sticky_lerr", 32'(line_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr2_lerr", 32'(line_err), 0);

        // Reset in the middle of a frame
        clear_mon();
        send_frame(-1, -1, -1, 4);
        chk("rst_mid_outputs", 32'(rst_snap), 0);
        chk("rst_mid_pre_writes", 32'(wc_at_rst), 32);
        chk("rst_mid_no_writes", 32'(wcount), 32'(wc_at_rst));
        chk("rst_mid_done", 32'(fdcnt), 0);
        chk("rst_mid_valid", 32'(frame_valid), 0);
        chk("rst_mid_busy", 32'(busy), 1);
        clear_mon();
        send_frame(-1, -1, -1, -1);
        chk("rst_next_writes", 32'(wcount), 64);
        chk("rst_next_bad", 32'(bad), 0);
        chk("rst_next_valid", 32'(frame_valid), 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
